// File: rtl/pci_target_pkg.sv
// Shared types and helpers for the burst-capable PCI SRAM target.
// Memory is organised in 32-bit dwords regardless of the bus width.
package pci_target_pkg;

  localparam int DW = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_WAIT = 3'd2,
    READ    = 3'd3,
    TURN    = 3'd4
  } state_e;

  function automatic logic [DW-1:0] byte_merge(
    input logic [DW-1:0]   old_w,
    input logic [DW-1:0]   new_w,
    input logic [DW/8-1:0] be_w
  );
    return {be_w[3] ? new_w[31:24] : old_w[31:24],
            be_w[2] ? new_w[23:16] : old_w[23:16],
            be_w[1] ? new_w[15:8]  : old_w[15:8],
            be_w[0] ? new_w[7:0]   : old_w[7:0]};
  endfunction

endpackage

// File: rtl/pci_dword_bank.sv
// One synchronous-read dword RAM with per-byte write enables.
// Contents are deliberately left out of reset.
module pci_dword_bank
  import pci_target_pkg::*;
#(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_r [WORDS];

  // byte-merging write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[waddr] <= byte_merge(mem_r[waddr], wdata, wbe);
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/pci_target_sram.sv
// Burst PCI memory target: window decode, byte-merging writes, prefetching
// reads and optional 64-bit phases split over an even and an odd dword bank.
module pci_target_sram
  import pci_target_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                addr_valid,
  input  logic [31:0]         addr_in,
  input  logic                we,
  input  logic [29:0]         win_start,
  input  logic [29:0]         win_end,
  input  logic                req_64,
  input  logic                data_valid,
  input  logic                burst_end,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] be,
  output logic                devsel_n,
  output logic                trdy_n,
  output logic                ack64_n,
  output logic [DATA_W-1:0]   data_out,
  output logic                last_add,
  output logic                target_abort
);

  localparam int IW = $clog2(DEPTH);
  localparam int BW = IW - 1;

  state_e          state_r, state_s;
  logic [IW-1:0]   idx_r, idx_s, end_r, end_s;
  logic            m64_r, m64_s;
  logic            done_s, abort_s, active_s;
  logic [29:0]     off_full_s, span_s;
  logic            hit_s;
  logic [IW-1:0]   step_s, rd_s, rd_p1_s, hi_idx_s;
  logic            wr_s, hi_wr_s;
  logic [DW-1:0]   q_even_s, q_odd_s, lo_rd_s;
  logic [DW-1:0]   hi_wd_s;
  logic [3:0]      hi_be_s;
  logic [DATA_W-1:0] load_s, dout_s;
  logic            we_e_s, we_o_s;
  logic [BW-1:0]   waddr_e_s, waddr_o_s, raddr_e_s, raddr_o_s;
  logic [DW-1:0]   wd_e_s, wd_o_s;
  logic [3:0]      be_e_s, be_o_s;
  logic            unused_s;

  function automatic logic is_last(input logic [IW-1:0] i, input logic [IW-1:0] e,
                                   input logic m);
    logic [IW:0] nxt;
    nxt = {1'b0, i} + {{IW{1'b0}}, 1'b1};
    if (m) begin
      return nxt >= {1'b0, e};
    end else begin
      return i == e;
    end
  endfunction

  assign off_full_s = addr_in[31:2] - win_start;
  assign span_s     = win_end - win_start;
  assign hit_s      = (addr_in[31:2] >= win_start) && (addr_in[31:2] <= win_end) &&
                      (off_full_s < 30'(DEPTH));
  assign step_s     = {{(IW-2){1'b0}}, m64_r, ~m64_r};
  assign done_s     = data_valid && ((state_r == WRITE) || (state_r == READ));
  assign unused_s   = ^{addr_in[1:0], rd_p1_s[0], hi_idx_s[0]};

  // next-state and burst bookkeeping
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    end_s   = end_r;
    m64_s   = m64_r;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (addr_valid && hit_s) begin
          idx_s   = off_full_s[IW-1:0];
          end_s   = (span_s > 30'(DEPTH - 1)) ? IW'(DEPTH - 1) : span_s[IW-1:0];
          m64_s   = (DATA_W == 64) && req_64 && !addr_in[2];
          state_s = we ? WRITE : RD_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE, READ: begin
        if (done_s) begin
          if (burst_end) begin
            state_s = TURN;
          end else if (last_add) begin
            // burst would run past the window: abort instead of wrapping
            abort_s = 1'b1;
            state_s = TURN;
          end else begin
            idx_s = idx_r + step_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      RD_WAIT: state_s = READ;
      TURN:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign active_s = (state_s == WRITE) || (state_s == RD_WAIT) || (state_s == READ);
  assign target_abort = abort_s && !rst;

  // Read pointer runs one phase ahead so READ never needs a bubble.
  assign rd_s      = idx_s + ((state_r == IDLE) ? {IW{1'b0}} : step_s);
  assign rd_p1_s   = rd_s + {{(IW-1){1'b0}}, 1'b1};
  assign raddr_e_s = rd_s[0] ? rd_p1_s[IW-1:1] : rd_s[IW-1:1];
  assign raddr_o_s = rd_s[IW-1:1];
  assign lo_rd_s   = idx_s[0] ? q_odd_s : q_even_s;

  generate
    if (DATA_W == 64) begin : g_w64
      logic [DW-1:0] hi_rd_s;
      assign hi_rd_s = idx_s[0] ? q_even_s : q_odd_s;
      assign load_s  = {(m64_s && (idx_s != end_s)) ? hi_rd_s : 32'h0000_0000, lo_rd_s};
      assign hi_wd_s = data_in[DATA_W-1:32];
      assign hi_be_s = be[DATA_W/8-1:4];
    end else begin : g_w32
      assign load_s  = lo_rd_s;
      assign hi_wd_s = '0;
      assign hi_be_s = '0;
    end
  endgenerate

  assign hi_idx_s  = idx_r + {{(IW-1){1'b0}}, 1'b1};
  assign hi_wr_s   = m64_r && (idx_r != end_r);
  assign wr_s      = done_s && (state_r == WRITE) && !rst;
  assign we_e_s    = wr_s && (!idx_r[0] || hi_wr_s);
  assign we_o_s    = wr_s && (idx_r[0] || hi_wr_s);
  assign waddr_e_s = idx_r[0] ? hi_idx_s[IW-1:1] : idx_r[IW-1:1];
  assign waddr_o_s = idx_r[IW-1:1];
  assign wd_e_s    = idx_r[0] ? hi_wd_s : data_in[31:0];
  assign wd_o_s    = idx_r[0] ? data_in[31:0] : hi_wd_s;
  assign be_e_s    = idx_r[0] ? hi_be_s : be[3:0];
  assign be_o_s    = idx_r[0] ? be[3:0] : hi_be_s;

  // read data register: load on entry to READ and on every completed phase
  always_comb begin
    dout_s = '0;
    if (state_s == READ) begin
      if ((state_r == RD_WAIT) || done_s) begin
        dout_s = load_s;
      end else begin
        dout_s = data_out;
      end
    end else begin
      dout_s = '0;
    end
  end

  // state and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      end_r    <= '0;
      m64_r    <= 1'b0;
      devsel_n <= 1'b1;
      trdy_n   <= 1'b1;
      ack64_n  <= 1'b1;
      data_out <= '0;
      last_add <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      end_r    <= end_s;
      m64_r    <= m64_s;
      devsel_n <= !active_s;
      trdy_n   <= !((state_s == WRITE) || (state_s == READ));
      ack64_n  <= !(active_s && m64_s);
      data_out <= dout_s;
      last_add <= active_s && is_last(idx_s, end_s, m64_s);
    end
  end

  pci_dword_bank #(.WORDS(DEPTH / 2), .AW(BW)) u_even (
    .clk   (clk),
    .wr_en (we_e_s),
    .waddr (waddr_e_s),
    .wdata (wd_e_s),
    .wbe   (be_e_s),
    .raddr (raddr_e_s),
    .rdata (q_even_s)
  );

  pci_dword_bank #(.WORDS(DEPTH / 2), .AW(BW)) u_odd (
    .clk   (clk),
    .wr_en (we_o_s),
    .waddr (waddr_o_s),
    .wdata (wd_o_s),
    .wbe   (be_o_s),
    .raddr (raddr_o_s),
    .rdata (q_odd_s)
  );

endmodule

// File: tb/tb_pci_target_sram.sv
// Directed bench for pci_target_sram: 64-bit bus, 128-dword memory,
// hand-computed expectations for writes, reads, window edges and reset.
module tb_pci_target_sram;

  logic        clk = 1'b0;
  logic        rst, addr_valid, we, req_64, data_valid, burst_end;
  logic [31:0] addr_in;
  logic [29:0] win_start, win_end;
  logic [63:0] data_in;
  logic [7:0]  be;
  logic        devsel_n, trdy_n, ack64_n, last_add, target_abort;
  logic [63:0] data_out;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [8];

  always #5 clk = ~clk;

  pci_target_sram #(.DATA_W(64), .DEPTH(128)) dut (
    .clk(clk), .rst(rst), .addr_valid(addr_valid), .addr_in(addr_in), .we(we),
    .win_start(win_start), .win_end(win_end), .req_64(req_64),
    .data_valid(data_valid), .burst_end(burst_end), .data_in(data_in), .be(be),
    .devsel_n(devsel_n), .trdy_n(trdy_n), .ack64_n(ack64_n), .data_out(data_out),
    .last_add(last_add), .target_abort(target_abort)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic r64,
                       input logic [29:0] ws, input logic [29:0] wend);
    win_start  = ws;
    win_end    = wend;
    addr_in    = a;
    we         = w;
    req_64     = r64;
    addr_valid = 1'b1;
    cyc();
    addr_valid = 1'b0;
  endtask

  task automatic wphase(input logic [63:0] d, input logic [7:0] b, input logic last);
    data_valid = 1'b1;
    data_in    = d;
    be         = b;
    burst_end  = last;
    cyc();
    data_valid = 1'b0;
    burst_end  = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [29:0] ws, input logic [29:0] wend,
                      input logic [31:0] d, input logic [3:0] b);
    start(a, 1'b1, 1'b0, ws, wend);
    wphase({32'h0, d}, {4'h0, b}, 1'b1);
    cyc();
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic r64, input logic [29:0] ws,
                          input logic [29:0] wend, input int n, input string tag);
    start(a, 1'b0, r64, ws, wend);
    @(negedge clk);
    check_val({tag, "_t1"}, {62'd0, devsel_n, trdy_n}, 64'd1);
    data_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i == n - 1) burst_end = 1'b1;
      @(negedge clk);
      check_val({tag, "_trdy"}, {63'd0, trdy_n}, 64'd0);
      check_val($sformatf("%s_d%0d", tag, i), data_out, exp_q[i]);
    end
    cyc();
    data_valid = 1'b0;
    burst_end  = 1'b0;
    @(negedge clk);
    check_val({tag, "_turn"}, {62'd0, devsel_n, trdy_n}, 64'd3);
    check_val({tag, "_turn_data"}, data_out, 64'd0);
    cyc();
  endtask

  initial begin
    rst = 1'b1; addr_valid = 1'b0; we = 1'b0; req_64 = 1'b0; data_valid = 1'b0;
    burst_end = 1'b0; addr_in = 32'h0; win_start = 30'h0; win_end = 30'h0;
    data_in = 64'h0; be = 8'h0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_ctl", {59'd0, devsel_n, trdy_n, ack64_n, last_add, target_abort}, 64'h1C);
    check_val("reset_data", data_out, 64'd0);

    // 4-phase zero-wait write with one stall cycle
    start(32'h0000_0100, 1'b1, 1'b0, 30'h40, 30'h4F);
    @(negedge clk);
    check_val("wr_t1", {61'd0, devsel_n, trdy_n, ack64_n}, 64'd1);
    check_val("wr_t1_last", {63'd0, last_add}, 64'd0);
    wphase(64'hAABB_CCDD, 8'h0F, 1'b0);
    cyc();
    wphase(64'h1000_0001, 8'h0F, 1'b0);
    wphase(64'h2000_0002, 8'h0F, 1'b0);
    wphase(64'h3000_0003, 8'h0F, 1'b1);
    @(negedge clk);
    check_val("wr_turn", {62'd0, devsel_n, trdy_n}, 64'd3);
    cyc();

    // partial byte-enable overwrite, then a gapless 4-dword read
    wr32(32'h0000_0100, 30'h40, 30'h4F, 32'h1122_3344, 4'h5);
    exp_q[0] = 64'hAA22_CC44; exp_q[1] = 64'h1000_0001;
    exp_q[2] = 64'h2000_0002; exp_q[3] = 64'h3000_0003;
    rd_burst(32'h0000_0100, 1'b0, 30'h40, 30'h4F, 4, "rd4");

    // 64-bit write and read-back, then per-dword view
    start(32'h0000_0100, 1'b1, 1'b1, 30'h40, 30'h4F);
    @(negedge clk);
    check_val("w64_ack", {61'd0, devsel_n, trdy_n, ack64_n}, 64'd0);
    wphase(64'h0102_0304_0506_0708, 8'hFF, 1'b1);
    cyc();
    exp_q[0] = 64'h0102_0304_0506_0708;
    rd_burst(32'h0000_0100, 1'b1, 30'h40, 30'h4F, 1, "r64");
    exp_q[0] = 64'h0506_0708; exp_q[1] = 64'h0102_0304;
    rd_burst(32'h0000_0100, 1'b0, 30'h40, 30'h4F, 2, "r64_dw");

    // 64-bit phase at the last window dword: upper half out of window
    wr32(32'h0000_013C, 30'h40, 30'h4F, 32'hDEAD_BEEF, 4'hF);
    start(32'h0000_0138, 1'b1, 1'b1, 30'h40, 30'h4E);
    @(negedge clk);
    check_val("w64_edge_last", {62'd0, last_add, ack64_n}, 64'd2);
    wphase(64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1);
    cyc();
    exp_q[0] = 64'h1234_5678;
    rd_burst(32'h0000_0138, 1'b1, 30'h40, 30'h4E, 1, "r64_edge");
    exp_q[0] = 64'hDEAD_BEEF;
    rd_burst(32'h0000_013C, 1'b0, 30'h40, 30'h4F, 1, "hi_dropped");

    // burst running off the window end
    wr32(32'h0000_0140, 30'h40, 30'h5F, 32'h55AA_55AA, 4'hF);
    start(32'h0000_0138, 1'b1, 1'b0, 30'h40, 30'h4F);
    @(negedge clk);
    check_val("abort_t1", {62'd0, last_add, target_abort}, 64'd0);
    data_valid = 1'b1; be = 8'h0F; burst_end = 1'b0; data_in = 64'h0E0E_0E0E;
    cyc();
    data_in = 64'h0F0F_0F0F;
    @(negedge clk);
    check_val("abort_pulse", {62'd0, last_add, target_abort}, 64'd3);
    cyc();
    @(negedge clk);
    check_val("abort_turn", {61'd0, devsel_n, trdy_n, target_abort}, 64'd6);
    data_valid = 1'b0;
    cyc();
    exp_q[0] = 64'h0E0E_0E0E; exp_q[1] = 64'h0F0F_0F0F; exp_q[2] = 64'h55AA_55AA;
    rd_burst(32'h0000_0138, 1'b0, 30'h40, 30'h5F, 3, "post_abort");

    // address misses: outside window, and offset beyond memory depth
    start(32'h0000_0200, 1'b1, 1'b0, 30'h40, 30'h4F);
    @(negedge clk);
    check_val("miss_win", {62'd0, devsel_n, trdy_n}, 64'd3);
    cyc();
    @(negedge clk);
    check_val("miss_win_t2", {63'd0, devsel_n}, 64'd1);
    start(32'h0000_0300, 1'b1, 1'b0, 30'h40, 30'h1000);
    @(negedge clk);
    check_val("miss_depth", {63'd0, devsel_n}, 64'd1);
    // last memory dword of an oversized window is flagged as last
    start(32'h0000_02FC, 1'b1, 1'b0, 30'h40, 30'h1000);
    @(negedge clk);
    check_val("clamp_last", {62'd0, devsel_n, last_add}, 64'd1);
    wphase(64'h0, 8'h00, 1'b1);
    cyc();

    // reset in the middle of a write burst
    start(32'h0000_0100, 1'b1, 1'b0, 30'h40, 30'h4F);
    wphase(64'h7777_7777, 8'h0F, 1'b0);
    data_valid = 1'b1; data_in = 64'h8888_8888; be = 8'h0F; rst = 1'b1;
    cyc();
    rst = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    check_val("rst_mid_ctl", {59'd0, devsel_n, trdy_n, ack64_n, last_add, target_abort}, 64'h1C);
    check_val("rst_mid_data", data_out, 64'd0);
    cyc();
    exp_q[0] = 64'h7777_7777; exp_q[1] = 64'h0102_0304;
    rd_burst(32'h0000_0100, 1'b0, 30'h40, 30'h4F, 2, "rst_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
